// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM-stage load/store handshake with lane steering and load formatting.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_byte_enable,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              access_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic is_ld, is_st, mem_op, legal, aligned, accept;
  logic ld_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [DATA_W-1:0] wdata_n, rsh, fmt;
  logic [3:0] be_n;
  always_comb begin
    is_ld   = opcode == 7'b0000011;
    is_st   = opcode == 7'b0100011;
    mem_op  = valid_in && (is_ld || is_st);
    legal   = is_ld ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                    : (funct3 inside {3'b000, 3'b001, 3'b010});
    aligned = funct3[1:0] == 2'b01 ? !addr[0] : funct3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1;
    accept  = state == IDLE && mem_op && legal && aligned;
    // rst gating keeps the handshake outputs quiet while reset is held
    stall      = !rst && (state == BUSY || accept);
    access_err = !rst && state == IDLE && mem_op && !(legal && aligned);
    wdata_n = is_ld ? '0 : funct3[1:0] == 2'b00 ? {4{store_data[7:0]}}
            : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    be_n    = is_ld ? 4'b1111 : funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
            : funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    rsh = dmem_rdata >> {off_q, 3'b000};
    fmt = f3_q == 3'b000 ? {{24{rsh[7]}}, rsh[7:0]}
        : f3_q == 3'b001 ? {{16{rsh[15]}}, rsh[15:0]}
        : f3_q == 3'b100 ? {24'h0, rsh[7:0]}
        : f3_q == 3'b101 ? {16'h0, rsh[15:0]} : dmem_rdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= 4'b0000;
      load_data        <= '0;
      ld_q             <= 1'b0;
      f3_q             <= 3'b000;
      off_q            <= 2'b00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state            <= BUSY;
          dmem_read        <= is_ld;
          dmem_write       <= is_st;
          dmem_address     <= {addr[ADDR_W-1:2], 2'b00};
          dmem_wdata       <= wdata_n;
          dmem_byte_enable <= be_n;
          ld_q             <= is_ld;
          f3_q             <= funct3;
          off_q            <= addr[1:0];
        end
        BUSY: if (dmem_resp) begin
          state      <= DONE;
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          if (ld_q) load_data <= fmt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit handshake, steering and formatting.
module tb_mem_access_unit;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
  logic clk = 0, rst = 1, valid_in = 0, dmem_resp = 0;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, dmem_rdata = 0;
  logic dmem_read, dmem_write, stall, access_err;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0] dmem_byte_enable;
  int n_cmp = 0, n_err = 0;
  int ns, nr, nw, nboth;
  logic [31:0] g_addr, g_wd;
  logic [3:0] g_be;
  logic d_stall, d_req;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct3(funct3),
    .addr(addr), .store_data(store_data), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .load_data(load_data),
    .stall(stall), .access_err(access_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // issue one access in an IDLE cycle, answer after `waits` BUSY cycles, return sampling DONE
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, sd,
                     input int waits, input logic [31:0] rd);
    @(negedge clk);
    valid_in = 1; opcode = op; funct3 = f3; addr = a; store_data = sd; dmem_resp = 0;
    ns = 0; nr = 0; nw = 0; nboth = 0;
    #1;
    if (stall) ns++;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (stall) ns++;
      if (dmem_read) nr++;
      if (dmem_write) nw++;
      if (dmem_read && dmem_write) nboth++;
      if (i == 0) begin g_addr = dmem_address; g_wd = dmem_wdata; g_be = dmem_byte_enable; end
      if (i == waits) begin dmem_resp = 1; dmem_rdata = rd; end
    end
    @(negedge clk);
    dmem_resp = 0;
    #1;
    d_stall = stall;
    d_req = dmem_read | dmem_write;
  endtask
  task automatic err_case(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    valid_in = 1; opcode = op; funct3 = f3; addr = a; store_data = 32'hFFFF_FFFF;
    #1;
    chk({tag, "_err"}, access_err, 1);
    chk({tag, "_stall"}, stall, 0);
    @(negedge clk);
    chk({tag, "_noreq"}, dmem_read | dmem_write, 0);
    valid_in = 0;
    #1;
    chk({tag, "_errpulse"}, access_err, 0);
  endtask
  initial begin
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_read", dmem_read, 0);
    chk("rst_write", dmem_write, 0);
    chk("rst_err", access_err, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_byte_enable, 0);
    chk("rst_ld", load_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    run(LD, 3'b010, 32'h1000_0008, 0, 2, 32'hDEAD_BEEF);
    chk("lw_read_cycles", nr, 3);
    chk("lw_stall_cycles", ns, 4);
    chk("lw_write_cycles", nw, 0);
    chk("lw_addr", g_addr, 32'h1000_0008);
    chk("lw_be", g_be, 4'b1111);
    chk("lw_done_stall", d_stall, 0);
    chk("lw_done_req", d_req, 0);
    chk("lw_data", load_data, 32'hDEAD_BEEF);
    run(LD, 3'b000, 32'h0000_2003, 0, 0, 32'h80FF_0011);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", ns, 2);
    run(LD, 3'b100, 32'h0000_2003, 0, 1, 32'h80FF_0011);
    chk("lbu_data", load_data, 32'h0000_0080);
    chk("lbu_stall_cycles", ns, 3);
    run(LD, 3'b001, 32'h0000_2002, 0, 0, 32'h80FF_0011);
    chk("lh_data", load_data, 32'hFFFF_80FF);
    run(LD, 3'b101, 32'h0000_2000, 0, 0, 32'h80FF_8011);
    chk("lhu_data", load_data, 32'h0000_8011);
    run(ST, 3'b000, 32'h0000_3001, 32'h1234_56AB, 0, 32'h5555_5555);
    chk("sb_write_cycles", nw, 1);
    chk("sb_read_cycles", nr, 0);
    chk("sb_wdata", g_wd, 32'hABAB_ABAB);
    chk("sb_be", g_be, 4'b0010);
    chk("sb_addr", g_addr, 32'h0000_3000);
    chk("sb_ld_kept", load_data, 32'h0000_8011);
    run(ST, 3'b001, 32'h0000_3002, 32'h1234_56AB, 0, 0);
    chk("sh_wdata", g_wd, 32'h56AB_56AB);
    chk("sh_be", g_be, 4'b1100);
    chk("sh_addr", g_addr, 32'h0000_3000);
    err_case("lw_misalign", LD, 3'b010, 32'h0000_4002);
    err_case("sh_misalign", ST, 3'b001, 32'h0000_4001);
    err_case("ld_f3_011", LD, 3'b011, 32'h0000_4000);
    err_case("st_f3_100", ST, 3'b100, 32'h0000_4000);
    @(negedge clk);
    valid_in = 1; opcode = ST; funct3 = 3'b010; addr = 32'h0000_5000; store_data = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstbusy_write_before", dmem_write, 1);
    #2 rst = 1;
    #1;
    chk("rstbusy_write_async", dmem_write, 0);
    chk("rstbusy_stall", stall, 0);
    chk("rstbusy_ld_cleared", load_data, 0);
    valid_in = 0;
    @(negedge clk);
    rst = 0; dmem_resp = 1; dmem_rdata = 32'h1111_1111;
    #1;
    chk("late_resp_stall", stall, 0);
    @(negedge clk);
    dmem_resp = 0;
    chk("late_resp_stall2", stall, 0);
    chk("late_resp_req", dmem_read | dmem_write, 0);
    chk("late_resp_ld", load_data, 0);
    run(LD, 3'b010, 32'h0000_6000, 0, 0, 32'h1111_1111);
    chk("b2b_lw_stall", ns, 2);
    chk("b2b_lw_read", nr, 1);
    chk("b2b_lw_done_stall", d_stall, 0);
    chk("b2b_lw_done_req", d_req, 0);
    run(ST, 3'b010, 32'h0000_6004, 32'h2222_2222, 0, 0);
    chk("b2b_sw_stall", ns, 2);
    chk("b2b_sw_write", nw, 1);
    chk("b2b_sw_read", nr, 0);
    chk("b2b_sw_wdata", g_wd, 32'h2222_2222);
    chk("b2b_sw_be", g_be, 4'b1111);
    chk("b2b_sw_addr", g_addr, 32'h0000_6004);
    chk("b2b_sw_done_stall", d_stall, 0);
    chk("b2b_ld_kept", load_data, 32'h1111_1111);
    valid_in = 0;
    @(negedge clk);
    chk("b2b_no_reissue_req", dmem_read | dmem_write, 0);
    chk("b2b_no_reissue_stall", stall, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
